// File: rtl/cpu_pkg.sv
// Shared types and constants for the divide issue controller.
package cpu_pkg;

  localparam int DIV_DW   = 32;
  // Word index of each result half inside the 2*DW divider output
  localparam int QUO_WORD = 1;
  localparam int REM_WORD = 0;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE,
    DRAIN
  } div_state_e;

endpackage

// File: rtl/div_axis_chan.sv
// One AXI-stream input channel of a divider IP: tvalid is raised on issue and
// dropped after its handshake; accepted stays high from the handshake on.
module div_axis_chan (
  input  logic clk,
  input  logic resetn,
  input  logic issue,
  input  logic tready,
  output logic tvalid,
  output logic accepted
);

  logic acc_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tvalid <= 1'b0;
      acc_q  <= 1'b0;
    end else if (issue) begin
      tvalid <= 1'b1;
      acc_q  <= 1'b0;
    end else if (tvalid && tready) begin
      tvalid <= 1'b0;
      acc_q  <= 1'b1;
    end
  end

  // Includes the handshake happening this cycle so ISSUE can leave on it
  assign accepted = acc_q | (tvalid & tready);

endmodule

// File: rtl/div_issue_ctrl.sv
// Sequences div.w/mod.w/div.wu/mod.wu onto the signed/unsigned AXI-stream dividers.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor is answered locally without the IPs.
module div_issue_ctrl
  import cpu_pkg::*;
#(
  parameter int DW = DIV_DW
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic            req_valid,
  input  logic            req_signed,
  input  logic            req_mod,
  input  logic [DW-1:0]   req_src1,
  input  logic [DW-1:0]   req_src2,
  output logic            req_ready,
  output logic            resp_valid,
  output logic [DW-1:0]   resp_result,
  input  logic            resp_ack,
  output logic            s_dividend_tvalid,
  output logic            s_divisor_tvalid,
  input  logic            s_dividend_tready,
  input  logic            s_divisor_tready,
  input  logic            s_dout_tvalid,
  input  logic [2*DW-1:0] s_dout_tdata,
  output logic            u_dividend_tvalid,
  output logic            u_divisor_tvalid,
  input  logic            u_dividend_tready,
  input  logic            u_divisor_tready,
  input  logic            u_dout_tvalid,
  input  logic [2*DW-1:0] u_dout_tdata,
  output logic [DW-1:0]   op_tdata_a,
  output logic [DW-1:0]   op_tdata_b,
  output logic            busy
);

  div_state_e      state, state_nxt;
  logic            sel_signed, sel_mod, flush_seen;
  logic            accept, zero_div, issue_s, issue_u;
  logic            s_dvd_acc, s_dvs_acc, u_dvd_acc, u_dvs_acc, both_acc;
  logic            dout_v;
  logic [2*DW-1:0] dout_d;
  logic [DW-1:0]   dout_pick;

  assign req_ready = (state == IDLE) & ~flush;
  assign accept    = req_valid & req_ready;

`ifdef DIV_ZERO_FAST_EN
  assign zero_div = (req_src2 == '0);
`else
  assign zero_div = 1'b0;
`endif

  assign issue_s = accept & ~zero_div & req_signed;
  assign issue_u = accept & ~zero_div & ~req_signed;

  div_axis_chan u_s_dvd (.clk(clk), .resetn(resetn), .issue(issue_s), .tready(s_dividend_tready),
                         .tvalid(s_dividend_tvalid), .accepted(s_dvd_acc));
  div_axis_chan u_s_dvs (.clk(clk), .resetn(resetn), .issue(issue_s), .tready(s_divisor_tready),
                         .tvalid(s_divisor_tvalid), .accepted(s_dvs_acc));
  div_axis_chan u_u_dvd (.clk(clk), .resetn(resetn), .issue(issue_u), .tready(u_dividend_tready),
                         .tvalid(u_dividend_tvalid), .accepted(u_dvd_acc));
  div_axis_chan u_u_dvs (.clk(clk), .resetn(resetn), .issue(issue_u), .tready(u_divisor_tready),
                         .tvalid(u_divisor_tvalid), .accepted(u_dvs_acc));

  // Only the IP chosen at accept time is ever listened to
  assign both_acc  = sel_signed ? (s_dvd_acc & s_dvs_acc) : (u_dvd_acc & u_dvs_acc);
  assign dout_v    = sel_signed ? s_dout_tvalid : u_dout_tvalid;
  assign dout_d    = sel_signed ? s_dout_tdata  : u_dout_tdata;
  assign dout_pick = sel_mod ? dout_d[REM_WORD*DW +: DW] : dout_d[QUO_WORD*DW +: DW];

  assign busy       = (state != IDLE);
  assign resp_valid = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = zero_div ? DONE : ISSUE;
      ISSUE: if (both_acc) state_nxt = (flush | flush_seen) ? DRAIN : WAIT;
      WAIT: begin
        if (dout_v)     state_nxt = flush ? IDLE : DONE;
        else if (flush) state_nxt = DRAIN;
      end
      DONE:  if (resp_ack | flush) state_nxt = IDLE;
      DRAIN: if (dout_v) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      sel_signed  <= 1'b0;
      sel_mod     <= 1'b0;
      flush_seen  <= 1'b0;
      op_tdata_a  <= '0;
      op_tdata_b  <= '0;
      resp_result <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        sel_signed <= req_signed;
        sel_mod    <= req_mod;
        op_tdata_a <= req_src1;
        op_tdata_b <= req_src2;
        flush_seen <= 1'b0;
      end else if (state == ISSUE && flush) begin
        flush_seen <= 1'b1;
      end
      if (accept && zero_div)
        resp_result <= req_mod ? req_src1 : '1;
      else if (state == WAIT && dout_v && !flush)
        resp_result <= dout_pick;
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: transaction-level model, bench-side divider IPs, directed scenarios.
module tb_div_issue_ctrl;

  logic        clk = 1'b0;
  logic        resetn, flush, req_valid, req_signed, req_mod, resp_ack;
  logic [31:0] req_src1, req_src2;
  logic        req_ready, resp_valid, busy;
  logic [31:0] resp_result, op_tdata_a, op_tdata_b;
  logic        s_dividend_tvalid, s_divisor_tvalid, s_dividend_tready, s_divisor_tready, s_dout_tvalid;
  logic        u_dividend_tvalid, u_divisor_tvalid, u_dividend_tready, u_divisor_tready, u_dout_tvalid;
  logic [63:0] s_dout_tdata, u_dout_tdata;

  div_issue_ctrl dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .req_valid(req_valid), .req_signed(req_signed), .req_mod(req_mod),
    .req_src1(req_src1), .req_src2(req_src2), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_result(resp_result), .resp_ack(resp_ack),
    .s_dividend_tvalid(s_dividend_tvalid), .s_divisor_tvalid(s_divisor_tvalid),
    .s_dividend_tready(s_dividend_tready), .s_divisor_tready(s_divisor_tready),
    .s_dout_tvalid(s_dout_tvalid), .s_dout_tdata(s_dout_tdata),
    .u_dividend_tvalid(u_dividend_tvalid), .u_divisor_tvalid(u_divisor_tvalid),
    .u_dividend_tready(u_dividend_tready), .u_divisor_tready(u_divisor_tready),
    .u_dout_tvalid(u_dout_tvalid), .u_dout_tdata(u_dout_tdata),
    .op_tdata_a(op_tdata_a), .op_tdata_b(op_tdata_b), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Divider IP behaviour: {quotient, remainder}; divide by zero gives all-ones / dividend
  function automatic logic [63:0] ip_result(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic [31:0] q, r;
    sa = a;
    sb = b;
    if (b == 0) begin q = '1; r = a; end
    else if (sgn) begin q = sa / sb; r = sa % sb; end
    else begin q = a / b; r = a % b; end
    return {q, r};
  endfunction

  function automatic logic [31:0] exp_word(input bit sgn, input bit md, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    r = ip_result(sgn, a, b);
    return md ? r[31:0] : r[63:32];
  endfunction

  // ---------------- transaction model ----------------
  bit          m_busy, m_have, m_pend_dvd, m_pend_dvs, m_killed, m_sel_s;
  logic [31:0] m_a, m_b, m_res;
  bit          rst_at_edge;

  always @(posedge clk) begin
    logic dv;
    rst_at_edge = !resetn;
    if (!resetn) begin
      m_busy = 0; m_have = 0; m_pend_dvd = 0; m_pend_dvs = 0; m_killed = 0;
      m_a = '0; m_b = '0;
    end else begin
      dv = m_sel_s ? s_dout_tvalid : u_dout_tvalid;
      if (m_have) begin
        if (resp_ack || flush) begin m_have = 0; m_busy = 0; end
      end else if (m_busy && !m_pend_dvd && !m_pend_dvs) begin
        if (dv) begin
          if (m_killed || flush) m_busy = 0;
          else m_have = 1;
        end else if (flush) m_killed = 1;
      end else if (m_busy) begin
        if (m_pend_dvd && (m_sel_s ? s_dividend_tready : u_dividend_tready)) m_pend_dvd = 0;
        if (m_pend_dvs && (m_sel_s ? s_divisor_tready : u_divisor_tready)) m_pend_dvs = 0;
        if (flush) m_killed = 1;
      end else if (req_valid && !flush) begin
        m_busy = 1; m_sel_s = req_signed; m_a = req_src1; m_b = req_src2; m_killed = 0;
        m_res = exp_word(req_signed, req_mod, req_src1, req_src2);
`ifdef DIV_ZERO_FAST_EN
        if (req_src2 == 0) m_have = 1;
        else begin m_pend_dvd = 1; m_pend_dvs = 1; end
`else
        m_pend_dvd = 1; m_pend_dvs = 1;
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && resetn) begin
      chk("req_ready", req_ready, !m_busy && !flush);
      chk("busy", busy, m_busy);
      chk("s_dividend_tvalid", s_dividend_tvalid, m_pend_dvd && m_sel_s);
      chk("s_divisor_tvalid", s_divisor_tvalid, m_pend_dvs && m_sel_s);
      chk("u_dividend_tvalid", u_dividend_tvalid, m_pend_dvd && !m_sel_s);
      chk("u_divisor_tvalid", u_divisor_tvalid, m_pend_dvs && !m_sel_s);
      chk("resp_valid", resp_valid, m_have);
      if (m_have) chk("resp_result", resp_result, m_res);
      if (m_pend_dvd || m_pend_dvs) begin
        chk("op_tdata_a", op_tdata_a, m_a);
        chk("op_tdata_b", op_tdata_b, m_b);
      end
    end
  end

  // ---------------- bench divider IPs ----------------
  int   dvd_wait = 0, dvs_wait = 0, dout_lat = 5;
  bit   junk_en = 1;
  int   cnt_dvd, cnt_dvs, dout_cnt;
  bit   hs_dvd, hs_dvs, p_dvd_v, p_dvd_r, p_dvs_v, p_dvs_r, rsp_sel_s, dout_arm, dvd_r, dvs_r;
  logic [63:0] dout_data;

  initial begin
    s_dividend_tready = 0; s_divisor_tready = 0; u_dividend_tready = 0; u_divisor_tready = 0;
    s_dout_tvalid = 0; u_dout_tvalid = 0; s_dout_tdata = '0; u_dout_tdata = '0;
    forever begin
      @(posedge clk); #1;
      s_dout_tvalid = 0; u_dout_tvalid = 0;
      if (rst_at_edge) begin
        cnt_dvd = 0; cnt_dvs = 0; hs_dvd = 0; hs_dvs = 0; dout_arm = 0;
        p_dvd_v = 0; p_dvd_r = 0; p_dvs_v = 0; p_dvs_r = 0;
        s_dividend_tready = 0; s_divisor_tready = 0; u_dividend_tready = 0; u_divisor_tready = 0;
        continue;
      end
      if (p_dvd_v && p_dvd_r) hs_dvd = 1;
      if (p_dvs_v && p_dvs_r) hs_dvs = 1;
      if (s_dividend_tvalid || s_divisor_tvalid) rsp_sel_s = 1;
      else if (u_dividend_tvalid || u_divisor_tvalid) rsp_sel_s = 0;
      p_dvd_v = s_dividend_tvalid | u_dividend_tvalid;
      p_dvs_v = s_divisor_tvalid | u_divisor_tvalid;
      if (p_dvd_v) begin dvd_r = (cnt_dvd >= dvd_wait); cnt_dvd++; end else begin dvd_r = 0; cnt_dvd = 0; end
      if (p_dvs_v) begin dvs_r = (cnt_dvs >= dvs_wait); cnt_dvs++; end else begin dvs_r = 0; cnt_dvs = 0; end
      p_dvd_r = dvd_r; p_dvs_r = dvs_r;
      s_dividend_tready = dvd_r & rsp_sel_s;  u_dividend_tready = dvd_r & !rsp_sel_s;
      s_divisor_tready  = dvs_r & rsp_sel_s;  u_divisor_tready  = dvs_r & !rsp_sel_s;
      if (hs_dvd && hs_dvs) begin
        hs_dvd = 0; hs_dvs = 0; dout_arm = 1; dout_cnt = dout_lat;
        dout_data = ip_result(rsp_sel_s, op_tdata_a, op_tdata_b);
      end
      if (dout_arm) begin
        if (dout_cnt <= 1) begin
          dout_arm = 0;
          if (rsp_sel_s) begin s_dout_tvalid = 1; s_dout_tdata = dout_data; end
          else begin u_dout_tvalid = 1; u_dout_tdata = dout_data; end
        end else dout_cnt--;
      end
      // Stray results on the IP not in use must be ignored
      if (junk_en && $urandom_range(0, 3) == 0) begin
        if (rsp_sel_s) begin u_dout_tvalid = 1; u_dout_tdata = {$urandom, $urandom}; end
        else begin s_dout_tvalid = 1; s_dout_tdata = {$urandom, $urandom}; end
      end
    end
  end

  // ---------------- directed sequence ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_req(input bit sgn, input bit md, input logic [31:0] a, input logic [31:0] b, input string nm);
    bit ok;
    tick();
    req_valid = 1; req_signed = sgn; req_mod = md; req_src1 = a; req_src2 = b;
    ok = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
      tick();
    end
    if (!ok) chk({nm, " accept timeout"}, 0, 1);
    tick();
    req_valid = 0;
  endtask

  task automatic wait_resp(input logic [31:0] exp, input bit sel_s, input string nm);
    bit ok, prev_d;
    ok = 0; prev_d = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (resp_valid) begin ok = 1; break; end
      prev_d = sel_s ? s_dout_tvalid : u_dout_tvalid;
    end
    if (!ok) chk({nm, " resp timeout"}, 0, 1);
    else begin
      chk({nm, " latency"}, prev_d, 1);
      chk({nm, " result"}, resp_result, exp);
    end
  endtask

  task automatic ack();
    tick(); resp_ack = 1;
    tick(); resp_ack = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    resetn = 0; flush = 0; req_valid = 0; req_signed = 0; req_mod = 0; resp_ack = 0;
    req_src1 = '0; req_src2 = '0;
    repeat (3) tick();
    resetn = 1;
    @(negedge clk);
    chk("rst req_ready", req_ready, 1);
    chk("rst busy", busy, 0);
    chk("rst resp_valid", resp_valid, 0);
    chk("rst resp_result", resp_result, 0);
    chk("rst op_a", op_tdata_a, 0);
    chk("rst tvalids", {s_dividend_tvalid, s_divisor_tvalid, u_dividend_tvalid, u_divisor_tvalid}, 0);
    chk_en = 1;

    // signed div.w -7/2, long IP latency, hold without ack
    dvd_wait = 0; dvs_wait = 0; dout_lat = 20;
    do_req(1, 0, 32'hFFFF_FFF9, 32'd2, "divw");
    wait_resp(32'hFFFF_FFFD, 1, "divw");
    repeat (3) begin
      @(negedge clk);
      chk("divw hold valid", resp_valid, 1);
      chk("divw hold result", resp_result, 32'hFFFF_FFFD);
    end
    ack();
    @(negedge clk);
    chk("divw ready after ack", req_ready, 1);

    // unsigned mod.wu 100/7 with staggered treadys; stray ack ignored
    dvd_wait = 1; dvs_wait = 4; dout_lat = 3;
    do_req(0, 1, 32'd100, 32'd7, "modwu");
    resp_ack = 1;
    repeat (3) @(negedge clk);
    chk("modwu dividend dropped", u_dividend_tvalid, 0);
    chk("modwu divisor held", u_divisor_tvalid, 1);
    chk("modwu signed idle", {s_dividend_tvalid, s_divisor_tvalid}, 0);
    tick(); resp_ack = 0;
    wait_resp(32'd2, 0, "modwu");
    ack();

    // flush in WAIT, then div.wu 9/3 must see its own result
    dvd_wait = 0; dvs_wait = 0; dout_lat = 10;
    do_req(0, 0, 32'd50, 32'd5, "stale");
    repeat (3) @(negedge clk);
    tick(); flush = 1;
    @(negedge clk);
    chk("wait flush busy", busy, 1);
    tick(); flush = 0;
    @(negedge clk);
    chk("drain blocks req", req_ready, 0);
    dout_lat = 2;
    do_req(0, 0, 32'd9, 32'd3, "after drain");
    wait_resp(32'd3, 0, "after drain");
    ack();

    // flush in ISSUE with a slow divisor channel
    dvd_wait = 0; dvs_wait = 5; dout_lat = 4;
    do_req(1, 0, 32'd20, 32'd3, "issue flush");
    flush = 1;
    tick(); flush = 0;
    repeat (4) begin
      @(negedge clk);
      chk("issue flush divisor held", s_divisor_tvalid, 1);
      chk("issue flush no resp", resp_valid, 0);
    end
    ok = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      chk("drain no resp", resp_valid, 0);
      if (!busy) begin ok = 1; break; end
    end
    chk("issue flush returns idle", ok, 1);

    // flush together with a request in IDLE
    tick(); flush = 1; req_valid = 1; req_signed = 0; req_mod = 0; req_src1 = 8; req_src2 = 2;
    @(negedge clk);
    chk("idle flush ready", req_ready, 0);
    tick(); flush = 0; req_valid = 0;
    @(negedge clk);
    chk("idle flush busy", busy, 0);
    chk("idle flush tvalids", {s_dividend_tvalid, s_divisor_tvalid, u_dividend_tvalid, u_divisor_tvalid}, 0);

    // zero divisor: mod.w 5/0 and div.w 7/0
    dvd_wait = 0; dvs_wait = 0; dout_lat = 3;
    do_req(1, 1, 32'd5, 32'd0, "mod0");
`ifdef DIV_ZERO_FAST_EN
    @(negedge clk);
    chk("mod0 fast valid", resp_valid, 1);
    chk("mod0 fast result", resp_result, 32'd5);
    chk("mod0 no tvalid", {s_dividend_tvalid, s_divisor_tvalid, u_dividend_tvalid, u_divisor_tvalid}, 0);
`else
    @(negedge clk);
    chk("mod0 issued signed", s_dividend_tvalid, 1);
    wait_resp(32'd5, 1, "mod0");
`endif
    ack();
    do_req(1, 0, 32'd7, 32'd0, "div0");
`ifdef DIV_ZERO_FAST_EN
    @(negedge clk);
    chk("div0 fast result", resp_result, 32'hFFFF_FFFF);
`else
    wait_resp(32'hFFFF_FFFF, 1, "div0");
`endif
    ack();

    // reset in the middle of an operation
    dout_lat = 10;
    do_req(0, 0, 32'd77, 32'd7, "midreset");
    tick(); resetn = 0;
    tick(); resetn = 1;
    @(negedge clk);
    chk("midreset busy", busy, 0);
    chk("midreset resp_valid", resp_valid, 0);
    chk("midreset result", resp_result, 0);
    chk("midreset tvalids", {s_dividend_tvalid, s_divisor_tvalid, u_dividend_tvalid, u_divisor_tvalid}, 0);

    // div.w -100/7, then flush while DONE
    dout_lat = 2;
    do_req(1, 0, -32'sd100, 32'd7, "neg");
    wait_resp(32'hFFFF_FFF2, 1, "neg");
    tick(); flush = 1;
    tick(); flush = 0;
    @(negedge clk);
    chk("done flush resp_valid", resp_valid, 0);
    chk("done flush ready", req_ready, 1);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
